// File: rtl/sap1_clk_pkg.sv
// sap1_clk_pkg: shared FSM state type and default parameters for the SAP-1 clock controller
package sap1_clk_pkg;
   typedef enum logic [1:0] {
      STEP   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_RUN_DIV         = 100_000_000;
endpackage

// File: rtl/input_debounce.sv
// input_debounce: synchroniser chain plus counter-based debouncer for one raw board input
module input_debounce
   import sap1_clk_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_WIDTH        = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   synced;
   assign synced  = sync_q[SYNC_STAGES-1];
   assign level_o = level_q;
   // shift the raw input in; count mismatching cycles and accept the new level once the count is full
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_d   = '0;
      level_d = level_q;
      if (synced != level_q) begin
         if (cnt_q == DB_WIDTH'(DEBOUNCE_CYCLES)) level_d = synced;
         else cnt_d = cnt_q + 1'b1;
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: run/step/halt FSM producing the SAP-1 master clock-enable pulse
module clock_step_controller
   import sap1_clk_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int RUN_DIV         = DEF_RUN_DIV,
   parameter int DIV_WIDTH       = $clog2(RUN_DIV + 1),
   parameter int DB_WIDTH        = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic run_mode_i,
   input  logic step_btn_i,
   input  logic halt_i,
   output logic mclk_en,
   output logic running_o,
   output logic halted_o
);
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(RUN_DIV - 1);
   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic                   en_q, en_d;
   logic                   hist_q, req_q, req_d;
   logic                   mode_db, btn_db;
   input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_WIDTH       (DB_WIDTH)
   ) u_mode_db (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .raw_i  (run_mode_i),
      .level_o(mode_db)
   );
   input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_WIDTH       (DB_WIDTH)
   ) u_btn_db (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .raw_i  (step_btn_i),
      .level_o(btn_db)
   );
   assign mclk_en   = en_q;
   assign running_o = state_q == RUN;
   assign halted_o  = state_q == HALTED;
   // a rising button edge only counts as a request while stepping, so leaving RUN with it held is silent
   assign req_d = btn_db & ~hist_q & (state_q == STEP);
   // next state, divider and enable; halt beats mode change beats pulse generation
   always_comb begin
      state_d = state_q;
      div_d   = '0;
      en_d    = 1'b0;
      unique case (state_q)
         STEP: begin
            if (halt_i) state_d = HALTED;
            else if (mode_db) state_d = RUN;
            else en_d = req_q;
         end
         RUN: begin
            if (halt_i) state_d = HALTED;
            else if (!mode_db) state_d = STEP;
            else begin
               div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
               en_d  = div_q == DIV_LAST;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = STEP;
      endcase
   end
   // state, divider, enable and edge-detect registers with synchronous active-low reset
   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state_q <= STEP;
         div_q   <= '0;
         en_q    <= 1'b0;
         hist_q  <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         en_q    <= en_d;
         hist_q  <= btn_db;
         req_q   <= req_d;
      end
   end
endmodule
